// File: rtl/ahb_printbuf_fifo.sv
// AHB-lite print/console buffer: CPU byte writes queue into a FIFO and
// drain over a paced valid/ready byte stream; STATUS/CTRL are bus-accessible.
module ahb_printbuf_fifo #(
  parameter int unsigned DEPTH        = 16,
  parameter bit          WAIT_ON_FULL = 1'b1,
  parameter int unsigned DRAIN_GAP    = 0,
  parameter bit          SIM_PRINT    = 1'b0
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic        HWRITE,
  input  logic [2:0]  HSIZE,
  input  logic [31:0] HWDATA,
  input  logic        HREADY,
  output logic        HREADYOUT,
  output logic        HRESP,
  output logic [31:0] HRDATA,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        irq
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned GW = (DRAIN_GAP > 0) ? $clog2(DRAIN_GAP + 1) : 1;

  typedef enum logic [1:0] {
    REG_DATA   = 2'd0,
    REG_STATUS = 2'd1,
    REG_CTRL   = 2'd2,
    REG_RSVD   = 2'd3
  } reg_sel_e;

  logic          dp_valid, dp_write;
  logic [3:0]    dp_addr;
  reg_sel_e      dp_reg;
  logic [7:0]    wr_byte;
  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic [GW-1:0] gap_cnt;
  logic          eot, ovf, tx_en, irq_en;
  logic          full, empty, is_eot;
  logic          data_wr, data_act, ctrl_wr, clear, push, pop, eot_set, ovf_set, stall;
  logic [7:0]    cnt8;
  logic          unused_bits;

  assign unused_bits = ^{HADDR[31:4], HSIZE, HTRANS[0]};

  // Address phase latch holds while HREADY is low, so a stalled write keeps its control.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      dp_valid <= 1'b0;
      dp_write <= 1'b0;
      dp_addr  <= '0;
    end else if (HREADY) begin
      dp_valid <= HSEL & HTRANS[1];
      dp_write <= HWRITE;
      dp_addr  <= HADDR[3:0];
    end
  end

  assign dp_reg = reg_sel_e'(dp_addr[3:2]);

  always_comb begin
    wr_byte = HWDATA[7:0];
    case (dp_addr[1:0])
      2'd1:    wr_byte = HWDATA[15:8];
      2'd2:    wr_byte = HWDATA[23:16];
      2'd3:    wr_byte = HWDATA[31:24];
      default: wr_byte = HWDATA[7:0];
    endcase
  end

  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);
  assign is_eot   = (wr_byte == 8'h04);
  assign data_wr  = dp_valid & dp_write & (dp_reg == REG_DATA);
  assign data_act = data_wr & HREADY;
  assign ctrl_wr  = dp_valid & dp_write & (dp_reg == REG_CTRL) & HREADY;
  assign clear    = ctrl_wr & HWDATA[1];
  assign stall    = WAIT_ON_FULL & data_wr & ~is_eot & full;
  assign push     = data_act & ~is_eot & ~full & ~clear;
  assign eot_set  = data_act & is_eot;
  assign ovf_set  = data_act & ~is_eot & full & ~WAIT_ON_FULL;

  assign tx_valid  = tx_en & ~empty & (gap_cnt == '0);
  assign tx_data   = empty ? 8'h00 : mem[rd_ptr];
  assign pop       = tx_valid & tx_ready;
  assign HREADYOUT = ~stall;
  assign HRESP     = 1'b0;

  always_ff @(posedge HCLK) begin
    if (push) mem[wr_ptr] <= wr_byte;
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      gap_cnt <= '0;
      eot     <= 1'b0;
      ovf     <= 1'b0;
      tx_en   <= 1'b1;
      irq_en  <= 1'b0;
      irq     <= 1'b0;
    end else begin
      // CLEAR wins over any push or pop landing on the same edge.
      if (clear) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
        eot    <= 1'b0;
        ovf    <= 1'b0;
      end else begin
        if (push) wr_ptr <= wr_ptr + AW'(1);
        if (pop)  rd_ptr <= rd_ptr + AW'(1);
        if (push && !pop)      count <= count + CW'(1);
        else if (!push && pop) count <= count - CW'(1);
        if (eot_set) eot <= 1'b1;
        if (ovf_set) ovf <= 1'b1;
      end
      if (pop && !clear)      gap_cnt <= GW'(DRAIN_GAP);
      else if (gap_cnt != '0) gap_cnt <= gap_cnt - GW'(1);
      if (ctrl_wr) begin
        tx_en  <= HWDATA[0];
        irq_en <= HWDATA[2];
      end
      irq <= irq_en & (eot | ovf);
    end
  end

  assign cnt8 = 8'(count);

  always_comb begin
    HRDATA = '0;
    if (dp_valid && !dp_write) begin
      case (dp_reg)
        REG_STATUS: HRDATA = {16'h0, cnt8, 4'h0, ovf, eot, full, empty};
        REG_CTRL:   HRDATA = {29'h0, irq_en, 1'b0, tx_en};
        default:    HRDATA = '0;
      endcase
    end
  end

  if (SIM_PRINT) begin : g_print
    always_ff @(posedge HCLK) begin
      if (!HRESET && pop && ((tx_data >= 8'h20 && tx_data < 8'h7f) || tx_data == 8'h0a))
        $write("%c", tx_data);
    end
  end

endmodule

// File: tb/tb_ahb_printbuf_fifo.sv
// Scoreboard bench for ahb_printbuf_fifo: a stalling/paced instance (a) and a
// dropping/back-to-back instance (b), checked against a queue-based model.
module tb_ahb_printbuf_fifo;
  localparam int unsigned DEPTH = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  logic        hsel   [2];
  logic [31:0] haddr  [2];
  logic [1:0]  htrans [2];
  logic        hwrite [2];
  logic [2:0]  hsize  [2];
  logic [31:0] hwdata [2];
  logic        hreadyout [2];
  logic        hresp  [2];
  logic [31:0] hrdata [2];
  logic [7:0]  txd    [2];
  logic        txv    [2];
  logic        txr    [2];
  logic        irq    [2];
  logic        hready [2];

  assign hready[0] = hreadyout[0];
  assign hready[1] = hreadyout[1];

  ahb_printbuf_fifo #(.DEPTH(DEPTH), .WAIT_ON_FULL(1'b1), .DRAIN_GAP(3), .SIM_PRINT(1'b0)) dut_a (
    .HCLK(clk), .HRESET(rst), .HSEL(hsel[0]), .HADDR(haddr[0]), .HTRANS(htrans[0]),
    .HWRITE(hwrite[0]), .HSIZE(hsize[0]), .HWDATA(hwdata[0]), .HREADY(hready[0]),
    .HREADYOUT(hreadyout[0]), .HRESP(hresp[0]), .HRDATA(hrdata[0]),
    .tx_data(txd[0]), .tx_valid(txv[0]), .tx_ready(txr[0]), .irq(irq[0]));

  ahb_printbuf_fifo #(.DEPTH(DEPTH), .WAIT_ON_FULL(1'b0), .DRAIN_GAP(0), .SIM_PRINT(1'b0)) dut_b (
    .HCLK(clk), .HRESET(rst), .HSEL(hsel[1]), .HADDR(haddr[1]), .HTRANS(htrans[1]),
    .HWRITE(hwrite[1]), .HSIZE(hsize[1]), .HWDATA(hwdata[1]), .HREADY(hready[1]),
    .HREADYOUT(hreadyout[1]), .HRESP(hresp[1]), .HRDATA(hrdata[1]),
    .tx_data(txd[1]), .tx_valid(txv[1]), .tx_ready(txr[1]), .irq(irq[1]));

  // Reference model: expected stream bytes per instance plus sticky flags / control bits.
  logic [7:0] exp_q [2][$];
  bit eot_m [2];
  bit ovf_m [2];
  bit txen_m [2];
  bit irqen_m [2];
  int pop_t [$];
  bit rnd0 = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h required 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < 2; i++) begin
      exp_q[i].delete();
      eot_m[i] = 1'b0;
      ovf_m[i] = 1'b0;
      txen_m[i] = 1'b1;
      irqen_m[i] = 1'b0;
    end
  endfunction

  function automatic logic [31:0] exp_reg(input int i, input logic [3:0] a);
    int n;
    n = exp_q[i].size();
    case (a[3:2])
      2'd1:    return {16'h0, 8'(n), 4'h0, ovf_m[i], eot_m[i], n >= int'(DEPTH), n == 0};
      2'd2:    return {29'h0, irqen_m[i], 1'b0, txen_m[i]};
      default: return 32'h0;
    endcase
  endfunction

  function automatic void model_write(input int i, input logic [3:0] a, input logic [31:0] d,
                                      input bit was_full);
    logic [7:0] b;
    b = d[8*a[1:0] +: 8];
    if (a[3:2] == 2'd0) begin
      if (b == 8'h04)     eot_m[i] = 1'b1;
      else if (!was_full) exp_q[i].push_back(b);
      else if (i == 1)    ovf_m[i] = 1'b1;
    end else if (a[3:2] == 2'd2) begin
      txen_m[i] = d[0];
      irqen_m[i] = d[2];
      if (d[1]) begin
        exp_q[i].delete();
        eot_m[i] = 1'b0;
        ovf_m[i] = 1'b0;
      end
    end
  endfunction

  function automatic logic [31:0] rand_data(input logic [1:0] a, input bit allow_eot);
    logic [31:0] d;
    logic [7:0] b;
    d = $urandom;
    b = 8'($urandom_range(5, 255));
    if (allow_eot && $urandom_range(0, 9) == 0) b = 8'h04;
    d[8*a +: 8] = b;
    return d;
  endfunction

  task automatic addr_phase(input int i, input logic [3:0] a, input logic wr, input logic [2:0] sz);
    hsel[i] = 1'b1;
    htrans[i] = 2'b10;
    hwrite[i] = wr;
    haddr[i] = {28'h0, a};
    hsize[i] = sz;
    @(posedge clk); #1;
    hsel[i] = 1'b0;
    htrans[i] = 2'b00;
  endtask

  task automatic bus_write(input int i, input logic [3:0] a, input logic [31:0] d, input logic [2:0] sz);
    int n;
    bit was_full;
    addr_phase(i, a, 1'b1, sz);
    hwdata[i] = d;
    n = 0;
    @(negedge clk);
    while (!hreadyout[i] && n < 300) begin
      n++;
      @(negedge clk);
    end
    if (n >= 300) check("stall_timeout", 32'(hreadyout[i]), 32'h1);
    was_full = exp_q[i].size() >= int'(DEPTH);
    @(posedge clk); #1;
    model_write(i, a, d, was_full);
  endtask

  task automatic bus_read_check(input int i, input logic [3:0] a, input string name);
    logic [31:0] e;
    addr_phase(i, a, 1'b0, 3'd2);
    @(negedge clk);
    e = exp_reg(i, a);
    check(name, hrdata[i], e);
    @(posedge clk); #1;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_drain(input int i, input int bound, input string name);
    int n;
    n = 0;
    while (exp_q[i].size() != 0 && n < bound) begin
      @(posedge clk); #1;
      n++;
    end
    check(name, exp_q[i].size(), 0);
  endtask

  task automatic monitor(input int i);
    forever begin
      @(negedge clk); #1;
      if (txv[i] && txr[i]) begin
        if (exp_q[i].size() == 0) begin
          checks++;
          errors++;
          $display("FAIL tx_unexpected[%0d]: got byte 0x%0h required no transfer", i, txd[i]);
        end else begin
          check($sformatf("tx_data[%0d]", i), 32'(txd[i]), 32'(exp_q[i].pop_front()));
          if (i == 0) pop_t.push_back(cyc);
        end
      end
    end
  endtask

  initial monitor(0);
  initial monitor(1);

  initial begin
    forever begin
      @(posedge clk); #1;
      if (rnd0) txr[0] = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0]  a;
    logic [31:0] d;
    for (int i = 0; i < 2; i++) begin
      hsel[i] = 1'b0; haddr[i] = '0; htrans[i] = '0; hwrite[i] = 1'b0;
      hsize[i] = '0; hwdata[i] = '0; txr[i] = 1'b0;
    end
    model_reset();
    rst = 1'b1;
    wait_cycles(3);
    for (int i = 0; i < 2; i++) begin
      check("rst_hreadyout", 32'(hreadyout[i]), 32'h1);
      check("rst_tx_valid", 32'(txv[i]), 32'h0);
      check("rst_tx_data", 32'(txd[i]), 32'h0);
      check("rst_irq", 32'(irq[i]), 32'h0);
      check("rst_hrdata", hrdata[i], 32'h0);
      check("rst_hresp", 32'(hresp[i]), 32'h0);
    end
    rst = 1'b0;
    wait_cycles(1);
    for (int i = 0; i < 2; i++) begin
      bus_read_check(i, 4'h8, "ctrl_reset");
      bus_read_check(i, 4'h4, "status_reset");
      bus_read_check(i, 4'hC, "reserved_read");
    end

    // Lane selection and first-byte latency on b.
    txr[1] = 1'b1;
    bus_write(1, 4'h0, 32'h0000_0041, 3'd2);
    check("b_latency_valid", 32'(txv[1]), 32'h1);
    bus_write(1, 4'h1, 32'hAABB_42CC, 3'd0);
    wait_drain(1, 20, "b_drain_lane");
    bus_read_check(1, 4'h4, "b_status_empty");

    // Overflow drop with IRQ on b.
    txr[1] = 1'b0;
    bus_write(1, 4'h8, 32'h5, 3'd2);
    for (int k = 0; k < 17; k++) bus_write(1, 4'h0, rand_data(2'd0, 1'b0), 3'd0);
    check("b_irq_before", 32'(irq[1]), 32'h0);
    wait_cycles(1);
    check("b_irq_ovf", 32'(irq[1]), 32'h1);
    bus_read_check(1, 4'h4, "b_status_full_ovf");
    bus_write(1, 4'h8, 32'h7, 3'd2);
    bus_read_check(1, 4'h4, "b_status_cleared");
    bus_read_check(1, 4'h8, "b_ctrl_after_clear");
    check("b_irq_cleared", 32'(irq[1]), 32'h0);

    // EOT marker is flagged, not queued.
    bus_write(1, 4'h0, 32'h33, 3'd0);
    bus_write(1, 4'h2, 32'h0004_0000, 3'd0);
    bus_read_check(1, 4'h4, "b_status_eot");
    check("b_irq_eot", 32'(irq[1]), 32'h1);
    bus_write(1, 4'h8, 32'h3, 3'd2);
    bus_read_check(1, 4'h4, "b_status_eot_clr");
    txr[1] = 1'b1;

    // Wait-state on full for a, released by a single pop.
    txr[0] = 1'b0;
    for (int k = 0; k < 16; k++) begin
      a = 4'($urandom_range(0, 3));
      bus_write(0, a, rand_data(a[1:0], 1'b0), 3'd0);
    end
    a = 4'h3;
    d = rand_data(2'd3, 1'b0);
    addr_phase(0, a, 1'b1, 3'd0);
    hwdata[0] = d;
    repeat (3) begin
      @(negedge clk);
      check("a_stall", 32'(hreadyout[0]), 32'h0);
    end
    @(posedge clk); #1;
    txr[0] = 1'b1;
    @(negedge clk);
    check("a_stall_pop_cycle", 32'(hreadyout[0]), 32'h0);
    @(posedge clk); #1;
    txr[0] = 1'b0;
    @(negedge clk);
    check("a_release", 32'(hreadyout[0]), 32'h1);
    @(posedge clk); #1;
    model_write(0, a, d, 1'b0);
    bus_read_check(0, 4'h4, "a_status_full_after_release");

    // Paced drain across the pointer wrap.
    pop_t.delete();
    txr[0] = 1'b1;
    wait_drain(0, 200, "a_drain_gap");
    check("a_pop_count", pop_t.size(), 16);
    for (int k = 1; k < pop_t.size(); k++) check("a_gap", pop_t[k] - pop_t[k-1], 4);

    // Randomized traffic on a with random consumer back-pressure.
    rnd0 = 1'b1;
    repeat (60) begin
      if ($urandom_range(0, 4) == 0) begin
        bus_read_check(0, 4'h4, "a_rand_status");
      end else begin
        a = 4'($urandom_range(0, 3));
        bus_write(0, a, rand_data(a[1:0], 1'b1), 3'($urandom_range(0, 2)));
      end
    end
    rnd0 = 1'b0;
    wait_cycles(1);
    txr[0] = 1'b1;
    wait_drain(0, 400, "a_rand_drain");

    // Reset during a stalled write.
    bus_write(0, 4'h8, 32'h5, 3'd2);
    bus_write(0, 4'h0, 32'h04, 3'd0);
    wait_cycles(2);
    check("a_irq_eot", 32'(irq[0]), 32'h1);
    txr[0] = 1'b0;
    wait_cycles(4);
    while (exp_q[0].size() < int'(DEPTH)) bus_write(0, 4'h0, rand_data(2'd0, 1'b0), 3'd2);
    addr_phase(0, 4'h0, 1'b1, 3'd2);
    hwdata[0] = rand_data(2'd0, 1'b0);
    @(negedge clk);
    check("a_stall_pre_reset", 32'(hreadyout[0]), 32'h0);
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check("a_rst_hreadyout", 32'(hreadyout[0]), 32'h1);
    check("a_rst_tx_valid", 32'(txv[0]), 32'h0);
    check("a_rst_irq", 32'(irq[0]), 32'h0);
    check("a_rst_hrdata", hrdata[0], 32'h0);
    hsel[0] = 1'b0;
    htrans[0] = 2'b00;
    @(posedge clk); #1;
    rst = 1'b0;
    wait_cycles(1);
    bus_read_check(0, 4'h8, "a_ctrl_after_reset");
    bus_read_check(0, 4'h4, "a_status_after_reset");

    wait_cycles(4);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
